// File: rtl/dbus_pkg.sv
// Shared types and widths for the TCM data-bus initiator and its store buffer.
// Optional store-to-load forwarding is enabled by defining DBUS_STORE_FWD_EN.
package dbus_pkg;

  localparam int unsigned DBUS_ADDR_W   = 32;
  localparam int unsigned DBUS_DATA_W   = 32;
  localparam int unsigned DBUS_BE_W     = DBUS_DATA_W / 8;
  localparam int unsigned DBUS_SB_DEPTH = 4;

  typedef struct packed {
    logic [DBUS_ADDR_W-1:0] addr;
    logic [DBUS_DATA_W-1:0] data;
    logic [DBUS_BE_W-1:0]   be;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } dbus_state_t;

endpackage

// File: rtl/dbus_sb_fifo.sv
// In-order store buffer for posted stores. With DBUS_STORE_FWD_EN defined it also
// exposes its live entries, oldest first, for load forwarding.
module dbus_sb_fifo
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH = DBUS_SB_DEPTH
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  sb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output logic      one_left,
  output sb_entry_t head
`ifdef DBUS_STORE_FWD_EN
  ,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic      [DEPTH-1:0] valid
`endif
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  sb_entry_t     mem [DEPTH];

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign one_left = (count == PW'(1));
  assign head     = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[IW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef DBUS_STORE_FWD_EN
  logic [PW-1:0] idx;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx        = rd_ptr + PW'(i);
      entries[i] = mem[idx[IW-1:0]];
      valid[i]   = (PW'(i) < count);
    end
  end
`endif

endmodule

// File: rtl/dbus_initiator.sv
// TCM initiator: posted in-order stores, single outstanding load after older stores.
// Define DBUS_STORE_FWD_EN to satisfy full-word loads directly from the store buffer.
module dbus_initiator
  import dbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DBUS_ADDR_W,
  parameter int unsigned DATA_WIDTH = DBUS_DATA_W,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SB_DEPTH   = DBUS_SB_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  idle,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_waitrequest
);

  dbus_state_t           state, state_n;
  logic                  ld_pending;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  sb_full, sb_empty, sb_one_left, sb_pop;
  sb_entry_t             sb_head, push_entry;
  logic                  accept, st_acc, ld_acc, ld_start, ld_next, rd_done;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign req_ready  = !ld_pending && !sb_full;
  assign accept     = req_valid && req_ready;
  assign st_acc     = accept && req_wr;
  assign ld_acc     = accept && !req_wr;
  assign ld_start   = ld_acc && !fwd_hit;
  assign ld_next    = ld_pending || ld_start;
  assign sb_pop     = (state == WR) && !mem_waitrequest;
  assign rd_done    = (state == RD) && !mem_waitrequest;
  assign idle       = sb_empty && !ld_pending && (state == IDLE);
  assign push_entry = '{addr: req_addr, data: req_wr_data, be: req_be};

`ifdef DBUS_STORE_FWD_EN
  sb_entry_t [SB_DEPTH-1:0] sb_entries;
  logic      [SB_DEPTH-1:0] sb_valid;

  // Scan oldest to youngest so the youngest matching word wins; a partial youngest match vetoes.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && (sb_entries[i].addr[ADDR_WIDTH-1:2] == req_addr[ADDR_WIDTH-1:2])) begin
        fwd_hit  = &sb_entries[i].be;
        fwd_data = sb_entries[i].data;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  dbus_sb_fifo #(.DEPTH(SB_DEPTH)) u_sb (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (st_acc),
    .push_data (push_entry),
    .pop       (sb_pop),
    .full      (sb_full),
    .empty     (sb_empty),
    .one_left  (sb_one_left),
    .head      (sb_head)
`ifdef DBUS_STORE_FWD_EN
    ,
    .entries   (sb_entries),
    .valid     (sb_valid)
`endif
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // A load accepted this cycle counts as pending so an empty buffer issues mem_rd next cycle.
  always_comb begin
    state_n     = state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_be   = '0;
    unique case (state)
      IDLE: begin
        if (!sb_empty)    state_n = WR;
        else if (ld_next) state_n = RD;
      end
      WR: begin
        mem_wr      = 1'b1;
        mem_addr    = sb_head.addr;
        mem_wr_data = sb_head.data;
        mem_wr_be   = sb_head.be;
        if (!mem_waitrequest) begin
          if (!sb_one_left || st_acc) state_n = WR;
          else if (ld_next)           state_n = RD;
          else                        state_n = IDLE;
        end
      end
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = ld_addr;
        if (!mem_waitrequest) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ld_pending <= 1'b0;
      ld_addr    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (ld_start) begin
        ld_pending <= 1'b1;
        ld_addr    <= req_addr;
      end else if (rd_done) begin
        ld_pending <= 1'b0;
      end
      rsp_valid <= rd_done || (ld_acc && fwd_hit);
      if (rd_done)                rsp_data <= mem_rd_data;
      else if (ld_acc && fwd_hit) rsp_data <= fwd_data;
    end
  end

endmodule

// File: tb/tb_dbus_initiator.sv
// Bench for dbus_initiator: transaction-level model (architectural memory plus pending-store
// queue) checked every cycle, with directed scenarios carrying literal expectations.
module tb_dbus_initiator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wr_data;
  logic [3:0]  req_be;
  logic        rsp_valid, idle;
  logic [31:0] rsp_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_rd, mem_wr, mem_waitrequest;
  logic [3:0]  mem_wr_be;

  always #5 clock = ~clock;

  dbus_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .SB_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_rd_data(mem_rd_data), .mem_waitrequest(mem_waitrequest)
  );

  int total = 0;
  int bad   = 0;

  // Responder: waits wait_n cycles on every strobe, or indefinitely while hold is set.
  logic        hold   = 1'b0;
  int          wait_n = 0;
  int          wcnt;
  logic [31:0] phys [256];
  logic [31:0] arch [256];

  assign mem_waitrequest = (mem_wr || mem_rd) && (hold || (wcnt < wait_n));
  assign mem_rd_data     = phys[mem_addr[9:2]];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)             wcnt <= 0;
    else if (mem_waitrequest) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  // Model: stores update arch at acceptance; a load must return arch at its acceptance.
  initial begin
    st_t         st_q [$];
    logic        load_out, rsp_due, prev_wait, fwd, found;
    logic [31:0] ld_a, ld_exp, rsp_exp, p_addr, p_data;
    logic [5:0]  p_ctl;
    load_out = 1'b0; rsp_due = 1'b0; prev_wait = 1'b0;
    ld_a = '0; ld_exp = '0; rsp_exp = '0; p_addr = '0; p_data = '0; p_ctl = '0;
    for (int i = 0; i < 256; i++) phys[i] = 32'h0;
    phys[8'h40] = 32'hDEADBEEF;
    phys[8'h12] = 32'hAABBCCDD;
    for (int i = 0; i < 256; i++) arch[i] = phys[i];
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("reset_strobes_rsp_idle", {mem_rd, mem_wr, rsp_valid, idle}, 4'b0001);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata_be", {mem_wr_data, mem_wr_be}, 36'h0);
        st_q.delete();
        load_out = 1'b0; rsp_due = 1'b0; prev_wait = 1'b0;
        for (int i = 0; i < 256; i++) arch[i] = phys[i];
      end else begin
        chk("strobe_excl", mem_rd && mem_wr, 1'b0);
        if (prev_wait) begin
          chk("hold_ctl", {mem_wr, mem_rd, mem_wr_be}, p_ctl);
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_data", mem_wr_data, p_data);
        end
        chk("ready", req_ready, !load_out && (st_q.size() < 4));
        chk("idle", idle, (st_q.size() == 0) && !load_out);
        chk("rsp_valid", rsp_valid, rsp_due);
        if (rsp_due) chk("rsp_data", rsp_data, rsp_exp);
        rsp_due = 1'b0;
        if (mem_wr) begin
          chk("wr_expected", st_q.size() != 0, 1'b1);
          if (st_q.size() != 0) begin
            chk("wr_addr", mem_addr, st_q[0].a);
            chk("wr_data", mem_wr_data, st_q[0].d);
            chk("wr_be", mem_wr_be, st_q[0].be);
          end
        end
        if (mem_rd) begin
          chk("rd_after_stores", {load_out, st_q.size() == 0}, 2'b11);
          chk("rd_addr", mem_addr, ld_a);
          if (!mem_waitrequest) begin
            rsp_due = 1'b1; rsp_exp = ld_exp; load_out = 1'b0;
          end
        end
        if (req_valid && req_ready) begin
          if (req_wr) begin
            arch[req_addr[9:2]] = merge(arch[req_addr[9:2]], req_wr_data, req_be);
            st_q.push_back('{a: req_addr, d: req_wr_data, be: req_be});
          end else begin
            fwd = 1'b0; found = 1'b0;
`ifdef DBUS_STORE_FWD_EN
            for (int i = st_q.size() - 1; i >= 0; i--) begin
              if (!found && (st_q[i].a[31:2] == req_addr[31:2])) begin
                found = 1'b1;
                fwd   = (st_q[i].be == 4'hF);
              end
            end
`endif
            if (fwd) begin
              rsp_due = 1'b1; rsp_exp = arch[req_addr[9:2]];
            end else begin
              load_out = 1'b1; ld_a = req_addr; ld_exp = arch[req_addr[9:2]];
            end
          end
        end
        if (mem_wr && !mem_waitrequest) begin
          phys[mem_addr[9:2]] = merge(phys[mem_addr[9:2]], mem_wr_data, mem_wr_be);
          if (st_q.size() != 0) void'(st_q.pop_front());
        end
        prev_wait = (mem_wr || mem_rd) && mem_waitrequest;
        p_ctl = {mem_wr, mem_rd, mem_wr_be}; p_addr = mem_addr; p_data = mem_wr_data;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int n;
    n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wr_data = d; req_be = be;
    while (!req_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("issue_timeout", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] exp);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        chk(name, rsp_data, exp);
      end else step();
    end
    if (!got) chk({name, "_timeout"}, rsp_valid, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && !idle; i++) step();
    chk(name, idle, 1'b1);
  endtask

  initial begin
    int cnt_wr, cnt_rsp;
    reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wr_data = '0; req_be = '0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    step();
    chk("t0_idle", idle, 1'b1);
    chk("t0_ready", req_ready, 1'b1);
    chk("t0_strobes", {mem_rd, mem_wr}, 2'b00);

    // Load 0x100 on an empty buffer: mem_rd at T+1, response at T+2.
    issue(1'b0, 32'h100, 32'h0, 4'h0);
    chk("t1_rd_at_T1", mem_rd, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_ready_low", req_ready, 1'b0);
    step();
    chk("t1_rsp_valid_T2", rsp_valid, 1'b1);
    chk("t1_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t1_ready_T2", req_ready, 1'b1);
    step();
    chk("t1_rsp_pulse", rsp_valid, 1'b0);
    chk("t1_idle", idle, 1'b1);

    // Fill the buffer while the responder stalls, then drain at one store per cycle.
    hold = 1'b1;
    for (int k = 0; k < 4; k++) issue(1'b1, 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF);
    chk("t2_full_ready", req_ready, 1'b0);
    chk("t2_head_held", {mem_wr, mem_addr}, {1'b1, 32'h0});
    hold = 1'b0;
    step();
    chk("t2_ready_after_pop", req_ready, 1'b1);
    for (int k = 1; k < 4; k++) begin
      chk("t2_b2b_addr", {mem_wr, mem_addr}, {1'b1, 32'(4 * k)});
      step();
    end
    chk("t2_drained", {mem_wr, idle}, 2'b01);
    chk("t2_mem0", phys[0], 32'hA0000000);
    chk("t2_mem3", phys[3], 32'hA0000003);

    // Store then load of the same word with three wait cycles per strobe.
    wait_n = 3;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp("t3_load_data", 32'h11223344);
    wait_idle("t3_idle");
    chk("t3_mem", phys[8], 32'h11223344);
    wait_n = 0;

    // Reset during a stalled write with a load queued behind it.
    hold = 1'b1;
    issue(1'b1, 32'h30, 32'h55AA55AA, 4'hF);
    issue(1'b0, 32'h34, 32'h0, 4'h0);
    for (int i = 0; i < 20 && !mem_wr; i++) step();
    chk("t4_wr_seen", mem_wr, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_async_drop", {mem_wr, mem_rd}, 2'b00);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    hold = 1'b0;
    cnt_wr = 0; cnt_rsp = 0;
    repeat (10) begin
      step();
      if (mem_wr) cnt_wr++;
      if (rsp_valid) cnt_rsp++;
    end
    chk("t4_no_wr", cnt_wr, 0);
    chk("t4_no_rsp", cnt_rsp, 0);
    chk("t4_idle", idle, 1'b1);
    chk("t4_mem_untouched", phys[12], 32'h0);

    // Full-word store held in the buffer, then a load of the same word.
    hold = 1'b1;
    issue(1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 4'h0);
`ifdef DBUS_STORE_FWD_EN
    chk("t5_fwd_valid_T1", rsp_valid, 1'b1);
    chk("t5_fwd_data", rsp_data, 32'hCAFEF00D);
    chk("t5_fwd_no_rd", mem_rd, 1'b0);
    hold = 1'b0;
`else
    chk("t5_no_early_rsp", rsp_valid, 1'b0);
    hold = 1'b0;
    wait_rsp("t5_full_data", 32'hCAFEF00D);
`endif
    wait_idle("t5_idle");

    // Partial-byte store: the load must be served by memory after the merge lands.
    hold = 1'b1;
    issue(1'b1, 32'h48, 32'h12345678, 4'h3);
    issue(1'b0, 32'h48, 32'h0, 4'h0);
    chk("t6_no_early_rsp", rsp_valid, 1'b0);
    hold = 1'b0;
    wait_rsp("t6_partial_data", 32'hAABB5678);
    wait_idle("t6_idle");
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
